// File: rtl/div8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div8_pkg
//  Purpose  : Shared state encoding and constants for the sequential divider.
//  Revision : 1.0
// ============================================================================
package div8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WIDTH_DEF = 8;

    // Quotient reported when the divisor is zero
    localparam logic [WIDTH_DEF-1:0] QERR = '1;

endpackage : div8_pkg
`default_nettype wire

// File: rtl/div8_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : div8_seq_if
//  Purpose  : Request/result bundle between the ALU control and the divider.
//  Revision : 1.0
// ============================================================================
interface div8_seq_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivError;

    modport master (
        output Start, Dividend, Divisor,
        input  Busy, Done, Quotient, Remainder, DivError
    );

    modport slave (
        input  Start, Dividend, Divisor,
        output Busy, Done, Quotient, Remainder, DivError
    );
endinterface : div8_seq_if
`default_nettype wire

// File: rtl/div_step8.sv
`default_nettype none
// ============================================================================
//  Module   : div_step8
//  Purpose  : One combinational restoring-division step.
//  Revision : 1.0
// ============================================================================
module div_step8 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] dsr_ext;

    always_comb begin
        // Incoming remainder is always < divisor, so the shift never loses a bit
        rem_sh  = (rem_i << 1) | {{WIDTH{1'b0}}, bit_i};
        dsr_ext = {1'b0, divisor_i};
        if (rem_sh >= dsr_ext) begin
            rem_o  = rem_sh - dsr_ext;
            qbit_o = 1'b1;
        end else begin
            rem_o  = rem_sh;
            qbit_o = 1'b0;
        end
    end

endmodule : div_step8
`default_nettype wire

// File: rtl/div8_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div8_seq
//  Purpose  : Sequential unsigned restoring divider, one bit per cycle.
//  Revision : 1.0
// ============================================================================
module div8_seq
    import div8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    div8_seq_if.slave  bus
);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   step_rem;
    logic             step_qbit;

    div_step8 #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (work_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        work_d  = work_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.Divisor != '0) begin
                        state_d = RUN;
                        work_d  = bus.Dividend;
                        dsr_d   = bus.Divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        quo_d   = QERR;
                        rmd_d   = bus.Dividend;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                // Dividend bits leave at the top while quotient bits enter at the bottom
                rem_d  = step_rem;
                work_d = {work_q[WIDTH-2:0], step_qbit};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'(WIDTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = {work_q[WIDTH-2:0], step_qbit};
                    rmd_d   = step_rem[WIDTH-1:0];
                    err_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            work_q  <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Quotient  = quo_q;
    assign bus.Remainder = rmd_q;
    assign bus.DivError  = err_q;

endmodule : div8_seq
`default_nettype wire

// File: tb/tb_div8_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div8_seq
//  Purpose  : Self-checking bench for div8_seq against an arithmetic model.
//  Revision : 1.0
// ============================================================================
module tb_div8_seq;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    div8_seq_if #(.WIDTH(8)) bus ();

    div8_seq #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation, observed for 14 cycles after the accepting edge.
    // pulse_at / rst_at inject a stray Start or a reset at that cycle (-1 = none).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input int pulse_at, input int rst_at);
        int         busy_n, done_n, done_k, exp_lat;
        logic [7:0] eq, er, q_obs, r_obs;
        logic       ee, e_obs;

        if (b == 8'd0) begin
            eq = 8'hFF; er = a; ee = 1'b1; exp_lat = 0;
        end else begin
            eq = a / b; er = a % b; ee = 1'b0; exp_lat = 8;
        end

        @(negedge clk);
        bus.Start = 1'b1; bus.Dividend = a; bus.Divisor = b;
        @(posedge clk);
        busy_n = 0; done_n = 0; done_k = -1;
        q_obs = '0; r_obs = '0; e_obs = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            rst = 1'b0;
            bus.Start    = 1'b0;
            bus.Dividend = 8'($urandom);
            bus.Divisor  = 8'($urandom);
            if (k == pulse_at) begin
                bus.Start = 1'b1; bus.Dividend = 8'd100; bus.Divisor = 8'd9;
            end
            if (k == rst_at) rst = 1'b1;
            if (bus.Busy) busy_n++;
            if (bus.Done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    q_obs  = bus.Quotient;
                    r_obs  = bus.Remainder;
                    e_obs  = bus.DivError;
                end
            end
        end
        rst = 1'b0;

        if (rst_at < 0) begin
            chk("done_count", done_n, 1);
            chk("done_latency", done_k, exp_lat);
            chk("busy_cycles", busy_n, (b == 8'd0) ? 0 : 8);
            chk("quotient", q_obs, eq);
            chk("remainder", r_obs, er);
            chk("diverror", e_obs, ee);
            chk("quotient_hold", bus.Quotient, eq);
            chk("remainder_hold", bus.Remainder, er);
            if (b != 8'd0) chk("rem_lt_div", (r_obs < b) ? 1 : 0, 1);
        end else begin
            chk("rst_no_done", done_n, 0);
            chk("rst_busy", bus.Busy, 0);
            chk("rst_quotient", bus.Quotient, 0);
            chk("rst_remainder", bus.Remainder, 0);
            chk("rst_diverror", bus.DivError, 0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.Start = 1'b0; bus.Dividend = '0; bus.Divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", bus.Busy, 0);
        chk("reset_done", bus.Done, 0);
        chk("reset_quotient", bus.Quotient, 0);
        chk("reset_remainder", bus.Remainder, 0);
        chk("reset_diverror", bus.DivError, 0);

        // Reset and Start on the same edge: reset wins, nothing starts
        bus.Start = 1'b1; bus.Dividend = 8'd40; bus.Divisor = 8'd3; rst = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0; rst = 1'b0;
        chk("rst_vs_start_busy", bus.Busy, 0);
        @(negedge clk);
        chk("rst_vs_start_busy2", bus.Busy, 0);
        chk("rst_vs_start_done", bus.Done, 0);

        run_op(8'd200, 8'd7,   -1, -1);
        run_op(8'd3,   8'd10,  -1, -1);
        run_op(8'd255, 8'd1,   -1, -1);
        run_op(8'd255, 8'd255, -1, -1);
        run_op(8'd5,   8'd0,   -1, -1);
        run_op(8'd9,   8'd3,   -1, -1);
        run_op(8'd0,   8'd0,   -1, -1);
        run_op(8'd50,  8'd6,    3, -1);
        run_op(8'd123, 8'd45,  -1,  4);
        run_op(8'd17,  8'd4,   -1, -1);

        for (int i = 0; i < 2000; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_div8_seq
`default_nettype wire
